credit_tx_gate: RTL and testbench

CREDIT_TX_GATE -- requirements
Module: credit_tx_gate

---
 rtl/credit_tx_gate.sv | 118 +++++++++++
 tb/tb_credit_tx_gate.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/credit_tx_gate.sv
// credit_tx_gate: forwards upstream words to a downstream receiver that
// cannot backpressure, spending one credit per word. The receiver returns
// credits with single-cycle pulses on crd_rtn. crd_reinit reloads the
// credit pool to CRD_INIT. crd_ovf_err flags a return that arrived while
// the pool was already full.
//
// Handshake: a word transfers in any cycle where s_valid && s_ready are both
// high on the rising clk edge. s_ready depends only on the registered credit
// count and crd_reinit, never on s_valid. The downstream side is a bare
// strobe: m_valid is high for exactly one cycle per transferred word, and
// m_data is valid in that same cycle.
module credit_tx_gate #(
    parameter int DATA_WIDTH = 32,
    parameter int CRD_WIDTH  = 8,
    parameter int CRD_INIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  crd_rtn,
    input  logic                  crd_reinit,
    output logic [CRD_WIDTH-1:0]  crd_cnt,
    output logic                  crd_zero,
    output logic                  crd_ovf_err,
    input  logic                  err_clr
);

    localparam logic [CRD_WIDTH-1:0] L_CRD_INIT = CRD_WIDTH'(CRD_INIT);
    localparam logic [CRD_WIDTH-1:0] L_CRD_ONE  = CRD_WIDTH'(1);

    logic [CRD_WIDTH-1:0]  r_crd_cnt;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_ovf_err;

    logic                  w_ready;
    logic                  w_send;
    logic                  w_cnt_full;
    logic                  w_ovf_set;
    logic [CRD_WIDTH-1:0]  w_crd_nxt;

    // A word may be taken while credits remain. A reload cycle is held off
    // so that the reload does not race with a spend.
    assign w_ready    = (r_crd_cnt != '0) && !crd_reinit;
    assign w_send     = s_valid && w_ready;
    assign w_cnt_full = (r_crd_cnt == L_CRD_INIT);

    // A return that finds the pool already full is an overflow. A return
    // that arrives together with a send or a reload is not.
    assign w_ovf_set  = crd_rtn && !w_send && !crd_reinit && w_cnt_full;

    // Next credit count. A reload wins over everything else. When a send and
    // a return happen together they cancel out. The count saturates at
    // CRD_INIT on the top end. No send is possible at zero, so the count
    // can never underflow.
    always_comb begin
        w_crd_nxt = r_crd_cnt;
        if (crd_reinit) begin
            w_crd_nxt = L_CRD_INIT;
        end else if (w_send && crd_rtn) begin
            w_crd_nxt = r_crd_cnt;
        end else if (w_send) begin
            w_crd_nxt = r_crd_cnt - L_CRD_ONE;
        end else if (crd_rtn && !w_cnt_full) begin
            w_crd_nxt = r_crd_cnt + L_CRD_ONE;
        end
    end

    // Credit counter register. Reset reloads the full pool.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crd_cnt <= L_CRD_INIT;
        end else begin
            r_crd_cnt <= w_crd_nxt;
        end
    end

    // Downstream strobe. It is high for one cycle after each send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
        end else begin
            r_m_valid <= w_send;
        end
    end

    // Payload register. It loads only on a send and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data <= '0;
        end else if (w_send) begin
            r_m_data <= s_data;
        end
    end

    // Sticky overflow flag. A new overflow wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_err <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf_err <= 1'b1;
        end else if (err_clr) begin
            r_ovf_err <= 1'b0;
        end
    end

    assign s_ready     = w_ready;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign crd_cnt     = r_crd_cnt;
    assign crd_zero    = (r_crd_cnt == '0);
    assign crd_ovf_err = r_ovf_err;

endmodule

// File: tb/tb_credit_tx_gate.sv
// tb_credit_tx_gate: directed scenarios followed by random traffic, all
// checked against a small credit-pool model kept in this bench.
module tb_credit_tx_gate;

    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int INIT = 4;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          crd_rtn;
    logic          crd_reinit;
    logic [CW-1:0] crd_cnt;
    logic          crd_zero;
    logic          crd_ovf_err;
    logic          err_clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    credit_tx_gate #(
        .DATA_WIDTH (DW),
        .CRD_WIDTH  (CW),
        .CRD_INIT   (INIT)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .crd_rtn     (crd_rtn),
        .crd_reinit  (crd_reinit),
        .crd_cnt     (crd_cnt),
        .crd_zero    (crd_zero),
        .crd_ovf_err (crd_ovf_err),
        .err_clr     (err_clr)
    );

    // ---------------- reference model + scoreboard ----------------
    int            mdl_credits;
    bit            mdl_err;
    bit            mdl_mv;
    logic [DW-1:0] mdl_md;
    logic [DW-1:0] exp_q[$];

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_credits = INIT;
        mdl_err     = 1'b0;
        mdl_mv      = 1'b0;
        mdl_md      = '0;
        exp_q.delete();
    endtask

    // One clock cycle. Inputs are applied just after a falling edge. The
    // model then advances by one cycle and the DUT outputs are checked at
    // the next falling edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit rtn,
                        input bit reinit, input bit clr);
        bit exp_ready;
        bit sent;
        s_valid    = v;
        s_data     = d;
        crd_rtn    = rtn;
        crd_reinit = reinit;
        err_clr    = clr;
        #1;
        exp_ready = (mdl_credits > 0) && !reinit;
        check("s_ready", s_ready, exp_ready);
        sent = v && exp_ready;
        if (sent) exp_q.push_back(d);
        @(posedge clk);
        // Credit rules, expressed as arithmetic on an integer pool.
        if (reinit) begin
            mdl_credits = INIT;
        end else if (sent && !rtn) begin
            mdl_credits = mdl_credits - 1;
        end else if (!sent && rtn) begin
            if (mdl_credits == INIT) mdl_err = 1'b1;
            else mdl_credits = mdl_credits + 1;
        end
        if (clr && !(rtn && !sent && !reinit && mdl_credits == INIT && !mdl_err_set_now(rtn, sent, reinit)))
            ;
        mdl_mv = sent;
        if (sent) mdl_md = exp_q.pop_front();
        @(negedge clk);
        check("m_valid", m_valid, mdl_mv);
        check("m_data", m_data, mdl_md);
        check("crd_cnt", crd_cnt, mdl_credits[CW-1:0]);
        check("crd_zero", crd_zero, mdl_credits == 0);
        check("crd_ovf_err", crd_ovf_err, mdl_err);
    endtask

    // Return with neither a send nor a reload in the same cycle. The error
    // clear itself is modelled in step_c() below.
    function automatic bit mdl_err_set_now(input bit rtn, input bit sent, input bit reinit);
        return rtn && !sent && !reinit;
    endfunction

    // Error-clear rule: a clear drops the flag unless an overflow is being
    // flagged in the same cycle.
    task automatic step_c(input bit v, input logic [DW-1:0] d, input bit rtn,
                          input bit reinit, input bit clr);
        bit ovf_now;
        ovf_now = rtn && !reinit && !(v && mdl_credits > 0) && (mdl_credits == INIT);
        if (clr && !ovf_now) begin
            // Update the model flag before step() compares against it.
            mdl_err = 1'b0;
        end
        step(v, d, rtn, reinit, clr);
    endtask

    task automatic do_reset(input int cycles);
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        crd_rtn    = 1'b0;
        crd_reinit = 1'b0;
        err_clr    = 1'b0;
        model_reset();
        repeat (cycles) @(negedge clk);
        check("rst_cnt", crd_cnt, INIT);
        check("rst_mv", m_valid, 1'b0);
        check("rst_md", m_data, 0);
        check("rst_err", crd_ovf_err, 1'b0);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        do_reset(3);

        // S1: s_valid held high for 6 cycles. Expect 4 strobes, then the pool is empty.
        for (int i = 0; i < 6; i++) begin
            step_c(1, 32'h1000_0000 + i, 0, 0, 0);
            check("s1_strobe", m_valid, i < 4);
        end
        check("s1_zero", crd_zero, 1'b1);
        check("s1_ready", s_ready, 1'b0);

        // S2: at zero credits, one return yields exactly one more send.
        step_c(1, 32'h2222_0001, 1, 0, 0);
        check("s2_cnt1", crd_cnt, 1);
        step_c(1, 32'h2222_0002, 0, 0, 0);
        check("s2_sent", m_valid, 1'b1);
        check("s2_cnt0", crd_cnt, 0);
        step_c(1, 32'h2222_0003, 0, 0, 0);
        check("s2_nosend", m_valid, 1'b0);

        // S3: reload, spend two credits, then a send and a return in the same cycle.
        step_c(0, 0, 0, 1, 0);
        step_c(1, 32'h3333_0001, 0, 0, 0);
        step_c(1, 32'h3333_0002, 0, 0, 0);
        check("s3_cnt2", crd_cnt, 2);
        step_c(1, 32'h3333_0003, 1, 0, 0);
        check("s3_hold", crd_cnt, 2);
        check("s3_mv", m_valid, 1'b1);

        // S4: overflow, clear, and a clear coincident with a new overflow.
        step_c(0, 0, 0, 1, 0);
        step_c(0, 0, 1, 0, 0);
        check("s4_cnt", crd_cnt, INIT);
        check("s4_err", crd_ovf_err, 1'b1);
        step_c(0, 0, 0, 0, 1);
        check("s4_clr", crd_ovf_err, 1'b0);
        step_c(0, 0, 1, 0, 1);
        check("s4_setwins", crd_ovf_err, 1'b1);
        step_c(0, 0, 0, 0, 1);

        // S5: at one credit, a reload together with s_valid and a return.
        step_c(1, 32'h5555_0001, 0, 0, 0);
        step_c(1, 32'h5555_0002, 0, 0, 0);
        step_c(1, 32'h5555_0003, 0, 0, 0);
        check("s5_cnt1", crd_cnt, 1);
        step_c(1, 32'h5555_0004, 1, 1, 0);
        check("s5_nosend", m_valid, 1'b0);
        check("s5_cnt", crd_cnt, INIT);
        check("s5_err", crd_ovf_err, 1'b0);

        // S6: asynchronous reset while m_valid=1 and crd_cnt=2.
        step_c(1, 32'h6666_0001, 0, 0, 0);
        step_c(1, 32'h6666_0002, 0, 0, 0);
        check("s6_pre_mv", m_valid, 1'b1);
        check("s6_pre_cnt", crd_cnt, 2);
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        model_reset();
        #1;
        check("s6_async_mv", m_valid, 1'b0);
        check("s6_async_cnt", crd_cnt, INIT);
        @(negedge clk);
        rst_n = 1'b1;
        step_c(1, 32'hA5A5_A5A5, 0, 0, 0);
        check("s6_data", m_data, 32'hA5A5_A5A5);
        check("s6_mv", m_valid, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step_c($urandom_range(0, 3) != 0, $urandom(),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends by itself.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
